// File: rtl/df_deadlock_detector_pkg.sv
// Shared types and constants for the dataflow deadlock monitor.
// Optional feature macro used by the monitor files: DF_DEADLOCK_CHAN_MASK_EN.
package df_monitor_pkg;

    localparam int STALL_RUN_W = 16;
    localparam logic [STALL_RUN_W-1:0] STALL_RUN_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        WATCH,
        SUSPECT,
        CONFIRMED,
        DONE
    } df_dl_state_t;

    function automatic logic [STALL_RUN_W-1:0] stall_run_inc(input logic [STALL_RUN_W-1:0] v);
        return (v == STALL_RUN_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/df_deadlock_detector_if.sv
// Signal bundle for the deadlock monitor, used at instantiation sites to group probes and results.
// DF_DEADLOCK_CHAN_MASK_EN adds the per-channel blocked probes and the latched channel mask.
interface df_deadlock_detector_if #(
    parameter int N_PROC = 5,
    parameter int N_CHAN = 2,
    parameter int CNT_W  = 32
);
    logic [N_PROC-1:0] proc_active;
    logic [N_PROC-1:0] proc_blocked;
    logic [N_CHAN-1:0] chan_rd_en;
    logic [N_CHAN-1:0] chan_wr_en;
    logic              finish;
    logic              find_df_deadlock;
    logic [N_PROC-1:0] deadlock_proc_mask;
    logic [CNT_W-1:0]  deadlock_cycle;
    logic [15:0]       stall_run;
`ifdef DF_DEADLOCK_CHAN_MASK_EN
    logic [N_CHAN-1:0] chan_blk_rd;
    logic [N_CHAN-1:0] chan_blk_wr;
    logic [N_CHAN-1:0] deadlock_chan_mask;
`endif

    modport master (
        output proc_active, proc_blocked, chan_rd_en, chan_wr_en, finish,
`ifdef DF_DEADLOCK_CHAN_MASK_EN
        output chan_blk_rd, chan_blk_wr,
        input  deadlock_chan_mask,
`endif
        input  find_df_deadlock, deadlock_proc_mask, deadlock_cycle, stall_run
    );

    modport slave (
        input  proc_active, proc_blocked, chan_rd_en, chan_wr_en, finish,
`ifdef DF_DEADLOCK_CHAN_MASK_EN
        input  chan_blk_rd, chan_blk_wr,
        output deadlock_chan_mask,
`endif
        output find_df_deadlock, deadlock_proc_mask, deadlock_cycle, stall_run
    );

endinterface

// File: rtl/df_deadlock_detector.sv
// Flags a dataflow deadlock once every active process has been blocked, with no FIFO traffic,
// for STALL_THRESH consecutive cycles. DF_DEADLOCK_CHAN_MASK_EN adds a latched channel mask.
module df_deadlock_detector
    import df_monitor_pkg::*;
#(
    parameter int N_PROC       = 5,
    parameter int N_CHAN       = 2,
    parameter int STALL_THRESH = 1024,
    parameter int CNT_W        = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_PROC-1:0] proc_active,
    input  logic [N_PROC-1:0] proc_blocked,
    input  logic [N_CHAN-1:0] chan_rd_en,
    input  logic [N_CHAN-1:0] chan_wr_en,
    input  logic              finish,
    output logic              find_df_deadlock,
    output logic [N_PROC-1:0] deadlock_proc_mask,
    output logic [CNT_W-1:0]  deadlock_cycle,
    output logic [15:0]       stall_run
`ifdef DF_DEADLOCK_CHAN_MASK_EN
    ,
    input  logic [N_CHAN-1:0] chan_blk_rd,
    input  logic [N_CHAN-1:0] chan_blk_wr,
    output logic [N_CHAN-1:0] deadlock_chan_mask
`endif
);

    df_dl_state_t           state_q, state_d;
    logic                   find_q, find_d;
    logic [N_PROC-1:0]      proc_mask_q, proc_mask_d;
    logic [CNT_W-1:0]       dl_cycle_q, dl_cycle_d;
    logic [STALL_RUN_W-1:0] stall_run_q, stall_run_d;
    logic [CNT_W-1:0]       cycle_cnt_q;
`ifdef DF_DEADLOCK_CHAN_MASK_EN
    logic [N_CHAN-1:0]      chan_mask_q, chan_mask_d;
`endif

    logic all_blk;
    logic progress;
    logic stalled;
    logic thresh_hit;

    assign all_blk  = (proc_active != '0) && ((proc_active & ~proc_blocked) == '0);
    assign progress = (|chan_rd_en) | (|chan_wr_en);
    assign stalled  = all_blk & ~progress;
    // True when this stalled cycle would be the STALL_THRESH-th; a saturated run never reaches a threshold above 65536.
    assign thresh_hit = (32'(stall_run_q) + 32'd1) >= 32'(STALL_THRESH);

    always_comb begin
        state_d     = state_q;
        find_d      = find_q;
        proc_mask_d = proc_mask_q;
        dl_cycle_d  = dl_cycle_q;
        stall_run_d = stall_run_q;
`ifdef DF_DEADLOCK_CHAN_MASK_EN
        chan_mask_d = chan_mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (finish)
                    state_d = DONE;
                else if (proc_active != '0)
                    state_d = WATCH;
            end
            WATCH, SUSPECT: begin
                if (finish) begin
                    state_d     = DONE;
                    stall_run_d = '0;
                end else if (!stalled) begin
                    state_d     = WATCH;
                    stall_run_d = '0;
                end else if (thresh_hit) begin
                    state_d     = CONFIRMED;
                    find_d      = 1'b1;
                    proc_mask_d = proc_blocked;
                    dl_cycle_d  = cycle_cnt_q;
                    stall_run_d = stall_run_inc(stall_run_q);
`ifdef DF_DEADLOCK_CHAN_MASK_EN
                    chan_mask_d = chan_blk_rd | chan_blk_wr;
`endif
                end else begin
                    state_d     = SUSPECT;
                    stall_run_d = stall_run_inc(stall_run_q);
                end
            end
            CONFIRMED: ;
            DONE: stall_run_d = '0;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            find_q      <= 1'b0;
            proc_mask_q <= '0;
            dl_cycle_q  <= '0;
            stall_run_q <= '0;
            cycle_cnt_q <= '0;
`ifdef DF_DEADLOCK_CHAN_MASK_EN
            chan_mask_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            find_q      <= find_d;
            proc_mask_q <= proc_mask_d;
            dl_cycle_q  <= dl_cycle_d;
            stall_run_q <= stall_run_d;
            if (cycle_cnt_q != '1)
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
`ifdef DF_DEADLOCK_CHAN_MASK_EN
            chan_mask_q <= chan_mask_d;
`endif
        end
    end

    assign find_df_deadlock   = find_q;
    assign deadlock_proc_mask = proc_mask_q;
    assign deadlock_cycle     = dl_cycle_q;
    assign stall_run          = stall_run_q;
`ifdef DF_DEADLOCK_CHAN_MASK_EN
    assign deadlock_chan_mask = chan_mask_q;
`endif

endmodule

// File: tb/tb_df_deadlock_detector.sv
// Scenario bench for df_deadlock_detector with STALL_THRESH=8; define DF_DEADLOCK_CHAN_MASK_EN
// to also cover the channel mask.
module tb_df_deadlock_detector;
    import df_monitor_pkg::*;

    localparam int N_PROC = 5;
    localparam int N_CHAN = 2;
    localparam int THRESH = 8;
    localparam int CNT_W  = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    df_deadlock_detector_if #(.N_PROC(N_PROC), .N_CHAN(N_CHAN), .CNT_W(CNT_W)) dif ();

    df_deadlock_detector #(
        .N_PROC(N_PROC), .N_CHAN(N_CHAN), .STALL_THRESH(THRESH), .CNT_W(CNT_W)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .proc_active        (dif.proc_active),
        .proc_blocked       (dif.proc_blocked),
        .chan_rd_en         (dif.chan_rd_en),
        .chan_wr_en         (dif.chan_wr_en),
        .finish             (dif.finish),
        .find_df_deadlock   (dif.find_df_deadlock),
        .deadlock_proc_mask (dif.deadlock_proc_mask),
        .deadlock_cycle     (dif.deadlock_cycle),
        .stall_run          (dif.stall_run)
`ifdef DF_DEADLOCK_CHAN_MASK_EN
        ,
        .chan_blk_rd        (dif.chan_blk_rd),
        .chan_blk_wr        (dif.chan_blk_wr),
        .deadlock_chan_mask (dif.deadlock_chan_mask)
`endif
    );

    typedef struct packed {
        logic [N_PROC-1:0] mask;
        logic [CNT_W-1:0]  dl_cycle;
        int                rise;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [N_PROC-1:0] act, input logic [N_PROC-1:0] blk,
                         input logic [N_CHAN-1:0] rd, input logic [N_CHAN-1:0] wr, input logic fin);
        dif.proc_active  = act;
        dif.proc_blocked = blk;
        dif.chan_rd_en   = rd;
        dif.chan_wr_en   = wr;
        dif.finish       = fin;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive('0, '0, '0, '0, 1'b0);
`ifdef DF_DEADLOCK_CHAN_MASK_EN
        dif.chan_blk_rd = '0;
        dif.chan_blk_wr = '0;
`endif
        step();
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Brings the FSM from IDLE to WATCH, then holds the all-blocked pattern for n cycles.
    task automatic enter_and_block(input logic [N_PROC-1:0] act, input logic [N_PROC-1:0] blk, input int n);
        drive(act, '0, '0, '0, 1'b0);
        step();
        drive(act, blk, '0, '0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
        checks++;
        if ({dif.find_df_deadlock, dif.deadlock_proc_mask, dif.deadlock_cycle, dif.stall_run} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got find=%b mask=%h cyc=%0d run=%0d exp all 0", dif.find_df_deadlock,
                     dif.deadlock_proc_mask, dif.deadlock_cycle, dif.stall_run);
        end
        checks++;
        if (dut.cycle_cnt_q !== 32'd0) begin errors++; $display("FAIL reset_cycle_cnt got=%0d exp=0", dut.cycle_cnt_q); end
        step();
        step();
        checks++;
        if (dut.cycle_cnt_q !== 32'd2) begin errors++; $display("FAIL cycle_cnt_run got=%0d exp=2", dut.cycle_cnt_q); end
        checks++;
        if (dut.state_q !== IDLE) begin errors++; $display("FAIL idle_hold got=%0d exp=%0d", dut.state_q, IDLE); end
        $display("test_reset done cyc=%0d", cyc);
    endtask

    task automatic test_basic_deadlock();
        exp_t e;
        int   w;
        do_reset();
        enter_and_block(5'h1F, 5'h1F, THRESH - 1);
        checks++;
        if (dif.stall_run !== 16'd7 || dif.find_df_deadlock !== 1'b0) begin
            errors++; $display("FAIL basic_pre run=%0d find=%b exp run=7 find=0", dif.stall_run, dif.find_df_deadlock);
        end
        sb_q.push_back('{mask: 5'h1F, dl_cycle: CNT_W'(cyc), rise: cyc + 1});
        step();
        w = 0;
        while (!dif.find_df_deadlock && w < 20) begin step(); w++; end
        checks++;
        if (!dif.find_df_deadlock) begin errors++; $display("FAIL basic_timeout find=0 exp=1"); end
        else begin
            e = sb_q.pop_front();
            checks += 3;
            if (cyc !== e.rise) begin errors++; $display("FAIL basic_rise got cyc=%0d exp=%0d", cyc, e.rise); end
            if (dif.deadlock_proc_mask !== e.mask) begin errors++; $display("FAIL basic_mask got=%h exp=%h", dif.deadlock_proc_mask, e.mask); end
            if (dif.deadlock_cycle !== e.dl_cycle) begin errors++; $display("FAIL basic_cycle got=%0d exp=%0d", dif.deadlock_cycle, e.dl_cycle); end
        end
        drive(5'h03, 5'h00, 2'b11, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (dut.state_q !== CONFIRMED || dif.find_df_deadlock !== 1'b1 || dif.deadlock_proc_mask !== 5'h1F
            || dif.stall_run !== 16'd8 || dif.deadlock_cycle !== CNT_W'(cyc - 4)) begin
            errors++;
            $display("FAIL confirmed_frozen state=%0d find=%b mask=%h run=%0d dcyc=%0d exp CONFIRMED 1 1f 8 %0d",
                     dut.state_q, dif.find_df_deadlock, dif.deadlock_proc_mask, dif.stall_run, dif.deadlock_cycle, cyc - 4);
        end
        $display("test_basic_deadlock done cyc=%0d", cyc);
    endtask

    task automatic test_progress_restart();
        exp_t e;
        int   w;
        do_reset();
        enter_and_block(5'h1F, 5'h1F, THRESH - 1);
        drive(5'h1F, 5'h1F, 2'b00, 2'b01, 1'b0);
        step();
        checks++;
        if (dif.stall_run !== 16'd0 || dut.state_q !== WATCH || dif.find_df_deadlock !== 1'b0) begin
            errors++; $display("FAIL progress_clear run=%0d state=%0d find=%b exp 0 WATCH 0", dif.stall_run, dut.state_q, dif.find_df_deadlock);
        end
        drive(5'h1F, 5'h1F, '0, '0, 1'b0);
        for (int i = 0; i < THRESH - 1; i++) step();
        checks++;
        if (dif.find_df_deadlock !== 1'b0 || dif.stall_run !== 16'd7) begin
            errors++; $display("FAIL progress_early find=%b run=%0d exp 0 7", dif.find_df_deadlock, dif.stall_run);
        end
        sb_q.push_back('{mask: 5'h1F, dl_cycle: CNT_W'(cyc), rise: cyc + 1});
        step();
        w = 0;
        while (!dif.find_df_deadlock && w < 20) begin step(); w++; end
        checks++;
        if (!dif.find_df_deadlock) begin errors++; $display("FAIL progress_timeout find=0 exp=1"); end
        else begin
            e = sb_q.pop_front();
            checks += 2;
            if (cyc !== e.rise) begin errors++; $display("FAIL progress_rise got cyc=%0d exp=%0d", cyc, e.rise); end
            if (dif.deadlock_cycle !== e.dl_cycle) begin errors++; $display("FAIL progress_cycle got=%0d exp=%0d", dif.deadlock_cycle, e.dl_cycle); end
        end
        $display("test_progress_restart done cyc=%0d", cyc);
    endtask

    task automatic test_partial_active();
        exp_t e;
        int   w;
        do_reset();
        enter_and_block(5'b00110, 5'b00110, THRESH - 1);
        sb_q.push_back('{mask: 5'b00110, dl_cycle: CNT_W'(cyc), rise: cyc + 1});
        step();
        w = 0;
        while (!dif.find_df_deadlock && w < 20) begin step(); w++; end
        checks++;
        if (!dif.find_df_deadlock) begin errors++; $display("FAIL partial_timeout find=0 exp=1"); end
        else begin
            e = sb_q.pop_front();
            checks += 3;
            if (cyc !== e.rise) begin errors++; $display("FAIL partial_rise got cyc=%0d exp=%0d", cyc, e.rise); end
            if (dif.deadlock_proc_mask !== e.mask) begin errors++; $display("FAIL partial_mask got=%h exp=%h", dif.deadlock_proc_mask, e.mask); end
            if (dif.deadlock_cycle !== e.dl_cycle) begin errors++; $display("FAIL partial_cycle got=%0d exp=%0d", dif.deadlock_cycle, e.dl_cycle); end
        end
        $display("test_partial_active done cyc=%0d", cyc);
    endtask

    task automatic test_proc_drop();
        do_reset();
        enter_and_block(5'h1F, 5'h1F, 3);
        checks++;
        if (dut.state_q !== SUSPECT || dif.stall_run !== 16'd3) begin
            errors++; $display("FAIL drop_suspect state=%0d run=%0d exp SUSPECT 3", dut.state_q, dif.stall_run);
        end
        drive(5'h00, 5'h1F, '0, '0, 1'b0);
        step();
        checks++;
        if (dut.state_q !== WATCH || dif.stall_run !== 16'd0) begin
            errors++; $display("FAIL drop_watch state=%0d run=%0d exp WATCH 0", dut.state_q, dif.stall_run);
        end
        $display("test_proc_drop done cyc=%0d", cyc);
    endtask

    task automatic test_finish_wins();
        logic seen;
        do_reset();
        enter_and_block(5'h1F, 5'h1F, THRESH - 1);
        drive(5'h1F, 5'h1F, '0, '0, 1'b1);
        step();
        checks++;
        if (dut.state_q !== DONE || dif.find_df_deadlock !== 1'b0) begin
            errors++; $display("FAIL finish_done state=%0d find=%b exp DONE 0", dut.state_q, dif.find_df_deadlock);
        end
        drive(5'h1F, 5'h1F, '0, '0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin step(); seen |= dif.find_df_deadlock; end
        checks++;
        if (seen !== 1'b0 || dut.state_q !== DONE) begin
            errors++; $display("FAIL finish_hold find_seen=%b state=%0d exp 0 DONE", seen, dut.state_q);
        end
        $display("test_finish_wins done cyc=%0d", cyc);
    endtask

    task automatic test_reset_in_confirmed();
        exp_t e;
        int   w;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        enter_and_block(5'h1F, 5'h1F, THRESH);
        checks++;
        if (dut.state_q !== CONFIRMED) begin errors++; $display("FAIL rc_pre state=%0d exp CONFIRMED", dut.state_q); end
        do_reset();
        checks++;
        if (dut.state_q !== IDLE || {dif.find_df_deadlock, dif.deadlock_proc_mask, dif.deadlock_cycle, dif.stall_run} !== '0) begin
            errors++;
            $display("FAIL rc_clear state=%0d find=%b mask=%h dcyc=%0d run=%0d exp IDLE all 0", dut.state_q,
                     dif.find_df_deadlock, dif.deadlock_proc_mask, dif.deadlock_cycle, dif.stall_run);
        end
        step();
        enter_and_block(5'h1F, 5'h1F, THRESH - 1);
        sb_q.push_back('{mask: 5'h1F, dl_cycle: CNT_W'(cyc), rise: cyc + 1});
        step();
        w = 0;
        while (!dif.find_df_deadlock && w < 20) begin step(); w++; end
        checks++;
        if (!dif.find_df_deadlock) begin errors++; $display("FAIL rc_timeout find=0 exp=1"); end
        else begin
            e = sb_q.pop_front();
            checks += 2;
            if (cyc !== e.rise) begin errors++; $display("FAIL rc_rise got cyc=%0d exp=%0d", cyc, e.rise); end
            if (dif.deadlock_cycle !== e.dl_cycle) begin errors++; $display("FAIL rc_cycle got=%0d exp=%0d", dif.deadlock_cycle, e.dl_cycle); end
        end
        $display("test_reset_in_confirmed done cyc=%0d", cyc);
    endtask

`ifdef DF_DEADLOCK_CHAN_MASK_EN
    task automatic test_chan_mask();
        int w;
        do_reset();
        checks++;
        if (dif.deadlock_chan_mask !== 2'b00) begin errors++; $display("FAIL chan_reset got=%b exp=00", dif.deadlock_chan_mask); end
        dif.chan_blk_rd = 2'b10;
        enter_and_block(5'h1F, 5'h1F, THRESH);
        w = 0;
        while (!dif.find_df_deadlock && w < 20) begin step(); w++; end
        checks++;
        if (dif.deadlock_chan_mask !== 2'b10) begin errors++; $display("FAIL chan_mask got=%b exp=10", dif.deadlock_chan_mask); end
        $display("test_chan_mask done cyc=%0d", cyc);
    endtask
`endif

    initial begin
        drive('0, '0, '0, '0, 1'b0);
`ifdef DF_DEADLOCK_CHAN_MASK_EN
        dif.chan_blk_rd = '0;
        dif.chan_blk_wr = '0;
`endif
        test_reset();
        test_basic_deadlock();
        test_progress_restart();
        test_partial_active();
        test_proc_drop();
        test_finish_wins();
        test_reset_in_confirmed();
`ifdef DF_DEADLOCK_CHAN_MASK_EN
        test_chan_mask();
`endif
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
